// File: rtl/ysyx_24120013_exu_mc_pkg.sv
// ysyx_24120013_exu_pkg: op codes, illegal-op range and FSM states for the multi-cycle EXU
// Contents: op_e (4-bit op enum), OP_ILLEGAL_MIN, state_e (IDLE/MUL/DONE), op_legal()
package ysyx_24120013_exu_pkg;
    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_PASSB = 4'd10,
        OP_MUL   = 4'd11
    } op_e;
    // codes from here up to 15 are illegal
    localparam logic [3:0] OP_ILLEGAL_MIN = 4'd12;
    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_e;
    function automatic logic op_legal(input logic [3:0] op);
        return op < OP_ILLEGAL_MIN;
    endfunction
endpackage

// File: rtl/ysyx_24120013_exu_mc_if.sv
// ysyx_24120013_exu_mc_if: IDU-to-EXU request channel and EXU-to-writeback result channel
// master: drives in_valid/op/use_imm/src1/src2/imm/rd/out_ready, observes in_ready/out_*/busy
// slave : the execute unit side
interface ysyx_24120013_exu_mc_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            op;
    logic                  use_imm;
    logic [DATA_WIDTH-1:0] src1;
    logic [DATA_WIDTH-1:0] src2;
    logic [DATA_WIDTH-1:0] imm;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_wen;
    logic [ADDR_WIDTH-1:0] out_waddr;
    logic [DATA_WIDTH-1:0] out_wdata;
    logic                  busy;
    modport master (
        output in_valid, op, use_imm, src1, src2, imm, rd, out_ready,
        input  in_ready, out_valid, out_wen, out_waddr, out_wdata, busy
    );
    modport slave (
        input  in_valid, op, use_imm, src1, src2, imm, rd, out_ready,
        output in_ready, out_valid, out_wen, out_waddr, out_wdata, busy
    );
endinterface

// File: rtl/ysyx_24120013_exu_mc_mul.sv
// ysyx_24120013_exu_mul: radix-2 shift-add multiplier, low DATA_WIDTH bits of a*b
// Ports: clk, rst (async, active-high), start (load a/b), a, b,
//        done (pulse on the final iteration), product (valid while done is high)
module ysyx_24120013_exu_mul #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] product
);
    localparam int CW = $clog2(DATA_WIDTH);
    logic                  run;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0] mplier;
    // product is the accumulator after the current iteration, so the caller
    // can capture the final value on the same edge that done is seen
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = run && cnt == CW'(DATA_WIDTH - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run    <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            run    <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (run) begin
            run    <= !done;
            cnt    <= cnt + 1'b1;
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
endmodule

// File: rtl/ysyx_24120013_exu_mc.sv
// ysyx_24120013_exu_mc: multi-cycle execute unit (single-cycle ALU + iterative MUL)
// Ports: clk, rst (async, active-high), bus (slave modport): request channel
//        in_valid/in_ready/op/use_imm/src1/src2/imm/rd, result channel
//        out_valid/out_ready/out_wen/out_waddr/out_wdata, busy during MUL iteration
module ysyx_24120013_exu_mc
    import ysyx_24120013_exu_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input logic clk,
    input logic rst,
    ysyx_24120013_exu_mc_if.slave bus
);
    localparam int SHAMT_W = $clog2(DATA_WIDTH);
    state_e                state;
    logic [DATA_WIDTH-1:0] opb;
    logic [DATA_WIDTH-1:0] alu;
    logic [DATA_WIDTH-1:0] product;
    logic [SHAMT_W-1:0]    sh;
    logic                  accept;
    logic                  is_mul;
    logic                  wen;
    logic                  mul_done;
    assign opb          = bus.use_imm ? bus.imm : bus.src2;
    assign sh           = opb[SHAMT_W-1:0];
    // DONE accepts only when the held result is consumed on the same edge
    assign bus.in_ready = state == IDLE || (state == DONE && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_mul       = bus.op == OP_MUL;
    assign wen          = op_legal(bus.op) && bus.rd != '0;
    always_comb begin
        alu = '0;
        case (bus.op)
            OP_ADD:   alu = bus.src1 + opb;
            OP_SUB:   alu = bus.src1 - opb;
            OP_AND:   alu = bus.src1 & opb;
            OP_OR:    alu = bus.src1 | opb;
            OP_XOR:   alu = bus.src1 ^ opb;
            OP_SLL:   alu = bus.src1 << sh;
            OP_SRL:   alu = bus.src1 >> sh;
            OP_SRA:   alu = $signed(bus.src1) >>> sh;
            OP_SLT:   alu = DATA_WIDTH'($signed(bus.src1) < $signed(opb));
            OP_SLTU:  alu = DATA_WIDTH'(bus.src1 < opb);
            OP_PASSB: alu = opb;
            default:  alu = '0;
        endcase
    end
    ysyx_24120013_exu_mul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (bus.src1),
        .b       (opb),
        .done    (mul_done),
        .product (product)
    );
    // out_waddr carries rd through the MUL iteration; it decides out_wen at the end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_wen   <= 1'b0;
            bus.out_waddr <= '0;
            bus.out_wdata <= '0;
        end else if (accept) begin
            state         <= is_mul ? MUL : DONE;
            bus.busy      <= is_mul;
            bus.out_valid <= !is_mul;
            bus.out_wen   <= !is_mul && wen;
            bus.out_waddr <= bus.rd;
            bus.out_wdata <= (!is_mul && wen) ? alu : '0;
        end else if (state == MUL && mul_done) begin
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.out_wen   <= bus.out_waddr != '0;
            bus.out_wdata <= bus.out_waddr != '0 ? product : '0;
        end else if (state == DONE && bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.out_wen   <= 1'b0;
        end
    end
endmodule
